mem_arbiter: RTL

Single-port memory arbiter sitting directly upstream of the team's synchronous single-port RAM (1-cycle read latency, en/we/addr/din/dout). Accepts read/write requests from NUM_CONSUMERS requesters (LSUs or fetchers) over a valid/ready handshake, grants one at a time in round-robin order, drives the RAM port, and returns read data to the granted requester. One transaction is outstanding at a time.

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the consumers and the memory arbiter.
// Per-consumer fields are flattened; consumer i owns slice [i*W +: W].
interface mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int MEM_ADDR_BITS = 8,
    parameter int MEM_DATA_BITS = 16
);
    logic [NUM_CONSUMERS-1:0]               req_valid;
    logic [NUM_CONSUMERS-1:0]               req_we;
    logic [NUM_CONSUMERS*MEM_ADDR_BITS-1:0] req_addr;
    logic [NUM_CONSUMERS*MEM_DATA_BITS-1:0] req_wdata;
    logic [NUM_CONSUMERS-1:0]               resp_ready;
    logic [NUM_CONSUMERS*MEM_DATA_BITS-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  resp_ready, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output resp_ready, resp_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a 1-cycle-latency single-port RAM.
// One transaction in flight; read data is returned into the winner's slice.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int MEM_ADDR_BITS = 8,
    parameter int MEM_DATA_BITS = 16,
    localparam int GID_BITS     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_arbiter_if.slave             bus,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [MEM_DATA_BITS-1:0] mem_din,
    input  logic [MEM_DATA_BITS-1:0] mem_dout,
    output logic                     busy,
    output logic [GID_BITS-1:0]      grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                             state_q, state_d;
    logic [GID_BITS-1:0]                rr_ptr;
    logic [GID_BITS-1:0]                winner;
    logic                               found;
    logic [GID_BITS-1:0]                next_ptr;
    logic [NUM_CONSUMERS-1:0]           resp_ready;
    logic [NUM_CONSUMERS*MEM_DATA_BITS-1:0] resp_rdata;

    assign bus.resp_ready = resp_ready;
    assign bus.resp_rdata = resp_rdata;
    assign busy           = (state_q != IDLE);
    assign next_ptr       = (grant_id == GID_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_id + 1'b1;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_CONSUMERS;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = GID_BITS'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = ISSUE;
            ISSUE:   state_d = mem_we ? DONE : WAIT;
            WAIT:    state_d = DONE;
            DONE:    if (!bus.req_valid[grant_id]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_ready <= '0;
            // NOTE: the read-data holding registers are cleared on reset because consumers observe them directly.
            resp_rdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        mem_en   <= 1'b1;
                        mem_we   <= bus.req_we[winner];
                        mem_addr <= bus.req_addr[winner*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                        mem_din  <= bus.req_wdata[winner*MEM_DATA_BITS +: MEM_DATA_BITS];
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) resp_ready[grant_id] <= 1'b1;
                end
                WAIT: begin
                    resp_rdata[grant_id*MEM_DATA_BITS +: MEM_DATA_BITS] <= mem_dout;
                    resp_ready[grant_id] <= 1'b1;
                end
                DONE: begin
                    // Completion is held until the consumer acknowledges by dropping valid.
                    if (!bus.req_valid[grant_id]) begin
                        resp_ready <= '0;
                        rr_ptr     <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
